operand_fetch_stage: RTL and testbench

- Second pipeline stage of the next-generation core, sitting between instruction fetch (stage 1) and execute (stage 3).
- Reads the register file and forwards results from both the execute and writeback stages.
- Detects load-use hazards and stalls the front end; resolves conditional and call redirects; drives the data-memory port.
- Replaces the unbounded wait with a counted wait, or a wait released by a wake event.

---
 rtl/operand_fetch_stage_if.sv | 29 ++
 rtl/operand_fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: register-file read port and data-memory port of the operand fetch stage
// Ports (master = operand_fetch_stage):
//   reg_read_addr0/1    master->slave  register file read addresses
//   reg_read_data0/1    slave->master  register file read data (combinational)
//   memory_addr         master->slave  data memory address
//   memory_write_enable master->slave  data memory write strobe
//   memory_in           master->slave  data memory write data
interface operand_fetch_stage_if #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int REG_BITS  = 3
);
    logic [REG_BITS-1:0]  reg_read_addr0;
    logic [REG_BITS-1:0]  reg_read_addr1;
    logic [WORD_SIZE-1:0] reg_read_data0;
    logic [WORD_SIZE-1:0] reg_read_data1;
    logic [ADDR_SIZE-1:0] memory_addr;
    logic                 memory_write_enable;
    logic [WORD_SIZE-1:0] memory_in;

    modport master (
        output reg_read_addr0, reg_read_addr1, memory_addr, memory_write_enable, memory_in,
        input  reg_read_data0, reg_read_data1
    );
    modport slave (
        input  reg_read_addr0, reg_read_addr1, memory_addr, memory_write_enable, memory_in,
        output reg_read_data0, reg_read_data1
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: stage 2 of the core -- operand read/forwarding, load-use stall, redirects, memory port, wait FSM
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   no_operation, ip, ip_plus_one, code_word   stage-1 instruction
//   flush                 kills the current instruction
//   wake                  releases an indefinite wait
//   ex_*, wb_*            stage-3 and writeback forwarding sources
//   bus                   register-file read port and data-memory port
//   stall_out             holds stage 1 on a load-use hazard
//   waiting_global        core-wide wait
//   ip_to_call, call_performed   redirect
//   *_out                 registered stage-3 payload
module operand_fetch_stage #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int REG_BITS  = 3,
    parameter int SP_REG    = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 no_operation,
    input  logic [ADDR_SIZE-1:0] ip,
    input  logic [ADDR_SIZE-1:0] ip_plus_one,
    input  logic [WORD_SIZE-1:0] code_word,
    input  logic                 flush,
    input  logic                 wake,
    input  logic                 ex_write_enable,
    input  logic [REG_BITS-1:0]  ex_write_addr,
    input  logic [WORD_SIZE-1:0] ex_write_data,
    input  logic                 ex_is_load,
    input  logic                 wb_write_enable,
    input  logic [REG_BITS-1:0]  wb_write_addr,
    input  logic [WORD_SIZE-1:0] wb_write_data,
    operand_fetch_stage_if.master bus,
    output logic                 stall_out,
    output logic                 waiting_global,
    output logic [ADDR_SIZE-1:0] ip_to_call,
    output logic                 call_performed,
    output logic                 no_operation_out,
    output logic [WORD_SIZE-1:0] alu_data0_out,
    output logic [WORD_SIZE-1:0] alu_data1_out,
    output logic [WORD_SIZE-1:0] code_word_out,
    output logic [ADDR_SIZE-1:0] ip_out,
    output logic [ADDR_SIZE-1:0] ip_plus_one_out,
    output logic [ADDR_SIZE-1:0] data1_plus_imm8_out
);
    localparam logic [3:0] OP_ALU              = 4'd0;
    localparam logic [3:0] OP_LOAD_FROM_MEMORY = 4'd1;
    localparam logic [3:0] OP_WRITE_TO_MEMORY  = 4'd2;
    localparam logic [3:0] OP_IF               = 4'd3;
    localparam logic [3:0] OP_CALL_IMM14       = 4'd4;
    localparam logic [3:0] OP_WAIT             = 4'd5;

    typedef enum logic [1:0] {RUN, WAIT_COUNT, WAIT_WAKE} state_t;

    state_t               state;
    logic [7:0]           cnt;
    logic [3:0]           op;
    logic [2:0]           ry;
    logic [7:0]           imm8;
    logic [WORD_SIZE-1:0] data0;
    logic [WORD_SIZE-1:0] data1;
    logic [ADDR_SIZE-1:0] imm_sext;
    logic [ADDR_SIZE-1:0] data1_plus_imm8;
    logic                 valid;
    logic                 hazard;
    logic                 fire;
    logic                 taken;
    logic                 is_call;

    // Condition codes carried in the ry field of OP_IF, tested on data0 as a signed word.
    function automatic logic if_ok(input logic [WORD_SIZE-1:0] d, input logic [2:0] c);
        logic z, n;
        z = d == '0;
        n = d[WORD_SIZE-1];
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n;
            3'd4:    return !n;
            3'd5:    return !n && !z;
            3'd6:    return n || z;
            default: return 1'b0;
        endcase
    endfunction

    assign op                 = code_word[17:14];
    assign ry                 = code_word[10:8];
    assign imm8               = code_word[7:0];
    assign bus.reg_read_addr0 = code_word[13:11];
    assign bus.reg_read_addr1 = (op == OP_CALL_IMM14) ? REG_BITS'(SP_REG) : ry;

    // ex results of a pending load are not yet available, so they never forward.
    assign data0 = (ex_write_enable && !ex_is_load && ex_write_addr == bus.reg_read_addr0) ? ex_write_data :
                   (wb_write_enable && wb_write_addr == bus.reg_read_addr0) ? wb_write_data : bus.reg_read_data0;
    assign data1 = (ex_write_enable && !ex_is_load && ex_write_addr == bus.reg_read_addr1) ? ex_write_data :
                   (wb_write_enable && wb_write_addr == bus.reg_read_addr1) ? wb_write_data : bus.reg_read_data1;

    assign imm_sext        = ADDR_SIZE'($signed(imm8));
    assign data1_plus_imm8 = ADDR_SIZE'(data1) + imm_sext;

    assign valid     = !no_operation && !flush && !waiting_global;
    assign hazard    = valid && ex_is_load && ex_write_enable &&
                       (ex_write_addr == bus.reg_read_addr0 || ex_write_addr == bus.reg_read_addr1);
    assign fire      = valid && !hazard;
    assign stall_out = hazard;
    assign taken     = fire && op == OP_IF && if_ok(data0, ry);
    assign is_call   = fire && op == OP_CALL_IMM14;

    assign bus.memory_write_enable = fire && (op == OP_WRITE_TO_MEMORY || op == OP_CALL_IMM14);
    assign bus.memory_addr         = is_call ? ADDR_SIZE'(data1) : data1_plus_imm8;
    assign bus.memory_in           = is_call ? WORD_SIZE'(ip_plus_one) : data0;
    assign call_performed          = is_call || taken;
    assign ip_to_call              = is_call ? ADDR_SIZE'(code_word[13:0]) : taken ? ip + imm_sext : data1_plus_imm8;

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= RUN;
            cnt                 <= '0;
            waiting_global      <= 1'b0;
            no_operation_out    <= 1'b1;
            alu_data0_out       <= '0;
            alu_data1_out       <= '0;
            code_word_out       <= '0;
            ip_out              <= '0;
            ip_plus_one_out     <= '0;
            data1_plus_imm8_out <= '0;
        end else begin
            no_operation_out    <= !valid || hazard || op == OP_WAIT;
            alu_data0_out       <= data0;
            alu_data1_out       <= taken ? WORD_SIZE'(ip) : data1;
            code_word_out       <= code_word;
            ip_out              <= ip;
            ip_plus_one_out     <= ip_plus_one;
            data1_plus_imm8_out <= data1_plus_imm8;
            case (state)
                RUN: if (fire && op == OP_WAIT) begin
                    state          <= (imm8 != 8'd0) ? WAIT_COUNT : WAIT_WAKE;
                    cnt            <= imm8;
                    waiting_global <= 1'b1;
                end
                // The cycle holding cnt == 1 is the last of the N waiting cycles.
                WAIT_COUNT: if (cnt == 8'd1) begin
                    state          <= RUN;
                    waiting_global <= 1'b0;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                WAIT_WAKE: if (wake) begin
                    state          <= RUN;
                    waiting_global <= 1'b0;
                end
                default: begin
                    state          <= RUN;
                    waiting_global <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: self-checking bench for operand_fetch_stage with directed scenarios and a random reference model
module tb_operand_fetch_stage;
    localparam int A = 18;
    localparam int W = 18;
    localparam int R = 3;
    localparam int MASK = 32'h3FFFF;
    localparam logic [3:0] OP_ALU = 4'd0, OP_LOAD = 4'd1, OP_WRITE = 4'd2, OP_IF = 4'd3, OP_CALL = 4'd4, OP_WAIT = 4'd5;

    logic         clock = 1'b0;
    logic         reset;
    logic         no_operation;
    logic [A-1:0] ip, ip_plus_one;
    logic [W-1:0] code_word;
    logic         flush, wake;
    logic         ex_write_enable, ex_is_load, wb_write_enable;
    logic [R-1:0] ex_write_addr, wb_write_addr;
    logic [W-1:0] ex_write_data, wb_write_data;
    logic         stall_out, waiting_global, call_performed, no_operation_out;
    logic [A-1:0] ip_to_call, ip_out, ip_plus_one_out, data1_plus_imm8_out;
    logic [W-1:0] alu_data0_out, alu_data1_out, code_word_out;
    logic [W-1:0] rf [8];
    int checks = 0;
    int fails = 0;

    always #5 clock = ~clock;

    operand_fetch_stage_if #(.ADDR_SIZE(A), .WORD_SIZE(W), .REG_BITS(R)) bus ();

    assign bus.reg_read_data0 = rf[bus.reg_read_addr0];
    assign bus.reg_read_data1 = rf[bus.reg_read_addr1];

    operand_fetch_stage #(.ADDR_SIZE(A), .WORD_SIZE(W), .REG_BITS(R), .SP_REG(7)) dut (
        .clock(clock), .reset(reset), .no_operation(no_operation), .ip(ip), .ip_plus_one(ip_plus_one),
        .code_word(code_word), .flush(flush), .wake(wake),
        .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr), .ex_write_data(ex_write_data),
        .ex_is_load(ex_is_load), .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr),
        .wb_write_data(wb_write_data), .bus(bus), .stall_out(stall_out), .waiting_global(waiting_global),
        .ip_to_call(ip_to_call), .call_performed(call_performed), .no_operation_out(no_operation_out),
        .alu_data0_out(alu_data0_out), .alu_data1_out(alu_data1_out), .code_word_out(code_word_out),
        .ip_out(ip_out), .ip_plus_one_out(ip_plus_one_out), .data1_plus_imm8_out(data1_plus_imm8_out)
    );

    function automatic logic [W-1:0] mk(input logic [3:0] op, input int rx, input int ry, input int imm);
        logic [2:0] x, y;
        logic [7:0] i;
        x = 3'(rx);
        y = 3'(ry);
        i = 8'(imm);
        return {op, x, y, i};
    endfunction

    function automatic int sext8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        no_operation = 1'b0; flush = 1'b0; wake = 1'b0;
        ex_write_enable = 1'b0; ex_is_load = 1'b0; ex_write_addr = '0; ex_write_data = '0;
        wb_write_enable = 1'b0; wb_write_addr = '0; wb_write_data = '0;
    endtask

    task automatic test_reset();
        quiet();
        no_operation = 1'b1; code_word = mk(OP_ALU, 1, 1, 1); ip = 18'h5; ip_plus_one = 18'h6;
        for (int i = 0; i < 8; i++) rf[i] = W'(i * 3 + 1);
        reset = 1'b1;
        tick(); tick();
        checks++; if (no_operation_out !== 1'b1) begin fails++; $display("FAIL reset_nop got %b want 1", no_operation_out); end
        checks++; if (waiting_global !== 1'b0) begin fails++; $display("FAIL reset_wait got %b want 0", waiting_global); end
        checks++; if ({alu_data0_out, alu_data1_out, code_word_out, ip_out, ip_plus_one_out, data1_plus_imm8_out} !== '0) begin
            fails++; $display("FAIL reset_payload got %h %h %h %h want all 0", alu_data0_out, code_word_out, ip_out, data1_plus_imm8_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        quiet();
        rf[2] = 18'd5; code_word = mk(OP_ALU, 2, 0, 0);
        wb_write_enable = 1'b1; wb_write_addr = 3'd2; wb_write_data = 18'd9;
        ex_write_enable = 1'b1; ex_write_addr = 3'd2; ex_write_data = 18'h3FFFF;
        #2;
        checks++; if (bus.reg_read_addr0 !== 3'd2) begin fails++; $display("FAIL fwd_addr0 got %0d want 2", bus.reg_read_addr0); end
        tick();
        checks++; if (alu_data0_out !== 18'h3FFFF) begin fails++; $display("FAIL fwd_ex got %h want 3ffff", alu_data0_out); end
        ex_write_enable = 1'b0;
        tick();
        checks++; if (alu_data0_out !== 18'd9) begin fails++; $display("FAIL fwd_wb got %h want 9", alu_data0_out); end
        wb_write_enable = 1'b0;
        tick();
        checks++; if (alu_data0_out !== 18'd5) begin fails++; $display("FAIL fwd_rf got %h want 5", alu_data0_out); end
    endtask

    task automatic test_load_use();
        quiet();
        rf[1] = 18'h77; rf[3] = 18'h40; code_word = mk(OP_WRITE, 1, 3, 5);
        ex_write_enable = 1'b1; ex_write_addr = 3'd3; ex_write_data = 18'h111; ex_is_load = 1'b1;
        #2;
        checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL lu_stall got %b want 1", stall_out); end
        checks++; if (bus.memory_write_enable !== 1'b0) begin fails++; $display("FAIL lu_we got %b want 0", bus.memory_write_enable); end
        tick();
        checks++; if (no_operation_out !== 1'b1) begin fails++; $display("FAIL lu_bubble got %b want 1", no_operation_out); end
        ex_write_enable = 1'b0; ex_is_load = 1'b0;
        #2;
        checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL lu_release got %b want 0", stall_out); end
        checks++; if ({bus.memory_write_enable, bus.memory_addr, bus.memory_in} !== {1'b1, 18'h45, 18'h77}) begin
            fails++; $display("FAIL lu_write got we=%b addr=%h din=%h want 1 45 77", bus.memory_write_enable, bus.memory_addr, bus.memory_in);
        end
        tick();
        checks++; if (no_operation_out !== 1'b0) begin fails++; $display("FAIL lu_issue got %b want 0", no_operation_out); end
    endtask

    task automatic test_call();
        quiet();
        rf[7] = 18'h100; ip = 18'h20; ip_plus_one = 18'h21; code_word = {OP_CALL, 14'h1234};
        #2;
        checks++; if (bus.reg_read_addr1 !== 3'd7) begin fails++; $display("FAIL call_sp got %0d want 7", bus.reg_read_addr1); end
        checks++; if ({bus.memory_write_enable, bus.memory_addr, bus.memory_in} !== {1'b1, 18'h100, 18'h21}) begin
            fails++; $display("FAIL call_push got we=%b addr=%h din=%h want 1 100 21", bus.memory_write_enable, bus.memory_addr, bus.memory_in);
        end
        checks++; if ({call_performed, ip_to_call} !== {1'b1, 18'h01234}) begin
            fails++; $display("FAIL call_redirect got %b %h want 1 01234", call_performed, ip_to_call);
        end
        tick();
    endtask

    task automatic test_branch();
        quiet();
        rf[0] = 18'd5; ip = 18'h10; ip_plus_one = 18'h11; code_word = mk(OP_IF, 0, 0, 8'hFE);
        #2;
        checks++; if ({call_performed, ip_to_call} !== {1'b1, 18'h0E}) begin
            fails++; $display("FAIL br_taken got %b %h want 1 0e", call_performed, ip_to_call);
        end
        tick();
        checks++; if (alu_data1_out !== 18'h10) begin fails++; $display("FAIL br_ip got %h want 10", alu_data1_out); end
        flush = 1'b1; ex_write_enable = 1'b1; ex_is_load = 1'b1; ex_write_addr = 3'd0;
        #2;
        checks++; if (call_performed !== 1'b0) begin fails++; $display("FAIL br_flush got %b want 0", call_performed); end
        checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL br_flush_stall got %b want 0", stall_out); end
        tick();
        checks++; if (no_operation_out !== 1'b1) begin fails++; $display("FAIL br_flush_nop got %b want 1", no_operation_out); end
        quiet();
        code_word = mk(OP_IF, 0, 1, 8'hFE);
        #2;
        checks++; if (call_performed !== 1'b0) begin fails++; $display("FAIL br_not_taken got %b want 0", call_performed); end
        tick();
    endtask

    task automatic test_counted_wait(input int n, input bit wake_mid);
        int cnt;
        bit nop_ok;
        quiet();
        code_word = mk(OP_WAIT, 0, 0, n);
        tick();
        code_word = mk(OP_ALU, 0, 0, 0);
        cnt = 0; nop_ok = 1'b1;
        for (int i = 0; i < 40 && waiting_global === 1'b1; i++) begin
            cnt++;
            if (no_operation_out !== 1'b1) nop_ok = 1'b0;
            wake = wake_mid && i == 0;
            tick();
        end
        wake = 1'b0;
        checks++; if (cnt != n) begin fails++; $display("FAIL cwait_len got %0d want %0d", cnt, n); end
        checks++; if (!nop_ok) begin fails++; $display("FAIL cwait_bubble got 0 want 1 during wait n=%0d", n); end
        tick();
        checks++; if (no_operation_out !== 1'b0) begin fails++; $display("FAIL cwait_resume got %b want 0", no_operation_out); end
    endtask

    task automatic test_wake_wait(input int hold);
        bit held;
        quiet();
        code_word = mk(OP_ALU, 0, 0, 0); wake = 1'b1;
        tick();
        wake = 1'b0;
        checks++; if (waiting_global !== 1'b0) begin fails++; $display("FAIL wwait_early_wake got %b want 0", waiting_global); end
        code_word = mk(OP_WAIT, 0, 0, 0);
        tick();
        code_word = mk(OP_ALU, 0, 0, 0);
        checks++; if (waiting_global !== 1'b1) begin fails++; $display("FAIL wwait_enter got %b want 1", waiting_global); end
        held = 1'b1; flush = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (waiting_global !== 1'b1 || no_operation_out !== 1'b1) held = 1'b0;
        end
        flush = 1'b0;
        checks++; if (!held) begin fails++; $display("FAIL wwait_hold got 0 want 1 for %0d cycles", hold); end
        wake = 1'b1;
        tick();
        wake = 1'b0;
        checks++; if (waiting_global !== 1'b0) begin fails++; $display("FAIL wwait_release got %b want 0", waiting_global); end
        tick();
        checks++; if (no_operation_out !== 1'b0) begin fails++; $display("FAIL wwait_resume got %b want 0", no_operation_out); end
    endtask

    task automatic test_reset_mid_wait();
        quiet();
        code_word = mk(OP_WAIT, 0, 0, 0);
        tick();
        code_word = mk(OP_ALU, 0, 0, 0);
        tick();
        checks++; if (waiting_global !== 1'b1) begin fails++; $display("FAIL rwait_enter got %b want 1", waiting_global); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({waiting_global, no_operation_out} !== 2'b01) begin
            fails++; $display("FAIL rwait_abort got wait=%b nop=%b want 0 1", waiting_global, no_operation_out);
        end
        tick();
        checks++; if ({waiting_global, no_operation_out} !== 2'b00) begin
            fails++; $display("FAIL rwait_run got wait=%b nop=%b want 0 0", waiting_global, no_operation_out);
        end
    endtask

    function automatic int model_read(input int a);
        if (ex_write_enable && !ex_is_load && int'(ex_write_addr) == a) return int'(ex_write_data);
        if (wb_write_enable && int'(wb_write_addr) == a) return int'(wb_write_data);
        return int'(rf[a]);
    endfunction

    task automatic test_random(input int iters);
        int op, rx, ry, imm, s, a1, d0, d1, d1p, sd, e_itc, e_addr, e_din, e_alu1;
        bit valid, hz, fire, tk, e_we, e_cp;
        logic [3:0] ops [10];
        ops = '{OP_ALU, OP_LOAD, OP_WRITE, OP_IF, OP_CALL, OP_IF, OP_WRITE, 4'd8, 4'd12, 4'd15};
        for (int it = 0; it < iters; it++) begin
            quiet();
            for (int i = 0; i < 8; i++) rf[i] = W'($urandom);
            op = int'(ops[$urandom_range(0, 9)]);
            rx = $urandom_range(0, 7); ry = $urandom_range(0, 7); imm = $urandom_range(0, 255);
            code_word = mk(4'(op), rx, ry, imm);
            no_operation = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 5) == 0);
            wake = $urandom_range(0, 1);
            ex_write_enable = $urandom_range(0, 1); ex_write_addr = R'($urandom); ex_write_data = W'($urandom);
            ex_is_load = ($urandom_range(0, 2) == 0);
            wb_write_enable = $urandom_range(0, 1); wb_write_addr = R'($urandom); wb_write_data = W'($urandom);
            ip = A'($urandom); ip_plus_one = ip + 18'd1;
            a1 = (op == OP_CALL) ? 7 : ry;
            d0 = model_read(rx); d1 = model_read(a1);
            s = sext8(imm);
            d1p = (d1 + s) & MASK;
            valid = !no_operation && !flush;
            hz = valid && ex_is_load && ex_write_enable && (int'(ex_write_addr) == rx || int'(ex_write_addr) == a1);
            fire = valid && !hz;
            sd = (d0 >= (1 << 17)) ? d0 - (1 << 18) : d0;
            case (ry)
                0: tk = 1; 1: tk = sd == 0; 2: tk = sd != 0; 3: tk = sd < 0;
                4: tk = sd >= 0; 5: tk = sd > 0; 6: tk = sd <= 0; default: tk = 0;
            endcase
            tk = tk && fire && op == OP_IF;
            e_we = fire && (op == OP_WRITE || op == OP_CALL);
            e_cp = tk || (fire && op == OP_CALL);
            e_addr = (fire && op == OP_CALL) ? d1 : d1p;
            e_din = (op == OP_CALL) ? int'(ip_plus_one) : d0;
            e_itc = (fire && op == OP_CALL) ? int'(code_word) & 32'h3FFF : tk ? (int'(ip) + s) & MASK : d1p;
            e_alu1 = tk ? int'(ip) : d1;
            #2;
            checks++; if (stall_out !== hz) begin fails++; $display("FAIL rnd_stall it=%0d got %b want %b", it, stall_out, hz); end
            checks++; if (bus.memory_write_enable !== e_we || bus.memory_addr !== A'(e_addr) || (e_we && bus.memory_in !== W'(e_din))) begin
                fails++; $display("FAIL rnd_mem it=%0d got %b %h %h want %b %h %h", it, bus.memory_write_enable, bus.memory_addr, bus.memory_in, e_we, e_addr, e_din);
            end
            checks++; if (call_performed !== e_cp || ip_to_call !== A'(e_itc)) begin
                fails++; $display("FAIL rnd_call it=%0d got %b %h want %b %h", it, call_performed, ip_to_call, e_cp, e_itc);
            end
            tick();
            checks++; if (no_operation_out !== (!valid || hz) || alu_data0_out !== W'(d0) || alu_data1_out !== W'(e_alu1)
                          || data1_plus_imm8_out !== A'(d1p) || code_word_out !== mk(4'(op), rx, ry, imm) || ip_plus_one_out !== ip_plus_one) begin
                fails++; $display("FAIL rnd_payload it=%0d got %b %h %h %h want %b %h %h %h", it, no_operation_out, alu_data0_out, alu_data1_out,
                                  data1_plus_imm8_out, !valid || hz, d0, e_alu1, d1p);
            end
            checks++; if (waiting_global !== 1'b0) begin fails++; $display("FAIL rnd_wait it=%0d got %b want 0", it, waiting_global); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_call();
        test_branch();
        test_counted_wait(3, 1'b0);
        test_counted_wait(1, 1'b0);
        test_counted_wait($urandom_range(2, 9), 1'b1);
        test_wake_wait($urandom_range(2, 5));
        test_reset_mid_wait();
        test_random(300);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
